// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle RV32I core: FSM states, opcode
// classes, fault codes and PC-source select codes.
package mc_pkg;

   typedef enum logic [2:0] {
      S_FETCH     = 3'd0,
      S_DECODE    = 3'd1,
      S_EXECUTE   = 3'd2,
      S_MEMORY    = 3'd3,
      S_WRITEBACK = 3'd4,
      S_HALT      = 3'd5
   } state_e;

   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   localparam logic [1:0] FAULT_NONE    = 2'b00;
   localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
   localparam logic [1:0] FAULT_TIMEOUT = 2'b10;
   localparam logic [1:0] FAULT_ECALL   = 2'b11;

   localparam logic [1:0] PCSEL_PLUS4 = 2'b00;
   localparam logic [1:0] PCSEL_ALU   = 2'b01;

   // Opcodes the core can execute (SYSTEM is handled separately as a trap).
   function automatic logic is_legal_op(input logic [6:0] op);
      case (op)
         OP_RTYPE, OP_ITYPE, OP_LOAD, OP_STORE, OP_BRANCH,
         OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: return 1'b1;
         default:                           return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/perf_counters.sv
// Free-running cycle counter (paused in HALT) and retired-instruction
// counter. Both wrap modulo 2^32.
module perf_counters (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        inc_i,
   input  logic        halt_i,
   output logic [31:0] cycle_count_o,
   output logic [31:0] instret_o
);

   logic [31:0] cycle_q;
   logic [31:0] instret_q;

   // Count non-HALT cycles and retire pulses.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cycle_q   <= '0;
         instret_q <= '0;
      end else begin
         if (!halt_i) cycle_q   <= cycle_q + 32'd1;
         if (inc_i)   instret_q <= instret_q + 32'd1;
      end
   end

   assign cycle_count_o = cycle_q;
   assign instret_o     = instret_q;

endmodule

// File: rtl/multicycle_sequencer.sv
// Multicycle control sequencer: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK FSM
// with req/ack memory handshakes, bus watchdog, halt/fault status and
// performance counters.
module multicycle_sequencer
   import mc_pkg::*;
#(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [6:0]  opcode,
   input  logic        branch_taken,
   input  logic        imem_ack,
   input  logic        dmem_ack,
   input  logic        resume,
   output logic        imem_req,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic        ir_write,
   output logic        operand_latch,
   output logic        pc_write,
   output logic [1:0]  pc_sel,
   output logic        reg_write,
   output logic [2:0]  state,
   output logic        halted,
   output logic [1:0]  fault,
   output logic [31:0] cycle_count,
   output logic [31:0] instret
);

   localparam int WDW = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;
   localparam logic [WDW-1:0] WD_LIMIT = WDW'(TIMEOUT);
   localparam logic WD_ON = (TIMEOUT != 0);

   state_e         state_q, state_d;
   logic [1:0]     fault_q, fault_d;
   logic [WDW-1:0] wait_q, wait_d;

   logic imem_req_c, dmem_req_c, dmem_we_c, ir_write_c, op_latch_c;
   logic pc_write_c, reg_write_c, retire_c;
   logic [1:0] pc_sel_c;
   logic wait_req, wait_ack, wd_expire;

   // State, fault and watchdog registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_FETCH;
         fault_q <= FAULT_NONE;
         wait_q  <= '0;
      end else begin
         state_q <= state_d;
         fault_q <= fault_d;
         wait_q  <= wait_d;
      end
   end

   // Next-state, enables and watchdog; a bus timeout overrides the stay decision.
   always_comb begin
      state_d     = state_q;
      fault_d     = fault_q;
      imem_req_c  = 1'b0;
      dmem_req_c  = 1'b0;
      dmem_we_c   = 1'b0;
      ir_write_c  = 1'b0;
      op_latch_c  = 1'b0;
      pc_write_c  = 1'b0;
      pc_sel_c    = PCSEL_PLUS4;
      reg_write_c = 1'b0;
      retire_c    = 1'b0;
      wait_req    = 1'b0;
      wait_ack    = 1'b0;
      case (state_q)
         S_FETCH: begin
            imem_req_c = 1'b1;
            wait_req   = 1'b1;
            wait_ack   = imem_ack;
            if (imem_ack) begin
               ir_write_c = 1'b1;
               state_d    = S_DECODE;
            end
         end
         S_DECODE: begin
            op_latch_c = 1'b1;
            if (opcode == OP_SYSTEM) begin
               state_d = S_HALT;
               fault_d = FAULT_ECALL;
            end else if (!is_legal_op(opcode)) begin
               state_d = S_HALT;
               fault_d = FAULT_ILLEGAL;
            end else begin
               state_d = S_EXECUTE;
            end
         end
         S_EXECUTE: begin
            if (opcode == OP_LOAD || opcode == OP_STORE) begin
               state_d = S_MEMORY;
            end else if (opcode == OP_BRANCH) begin
               pc_write_c = 1'b1;
               pc_sel_c   = branch_taken ? PCSEL_ALU : PCSEL_PLUS4;
               retire_c   = 1'b1;
               state_d    = S_FETCH;
            end else begin
               state_d = S_WRITEBACK;
            end
         end
         S_MEMORY: begin
            dmem_req_c = 1'b1;
            dmem_we_c  = (opcode == OP_STORE);
            wait_req   = 1'b1;
            wait_ack   = dmem_ack;
            if (dmem_ack) begin
               if (opcode == OP_STORE) begin
                  pc_write_c = 1'b1;
                  retire_c   = 1'b1;
                  state_d    = S_FETCH;
               end else begin
                  state_d = S_WRITEBACK;
               end
            end
         end
         S_WRITEBACK: begin
            reg_write_c = 1'b1;
            pc_write_c  = 1'b1;
            pc_sel_c    = (opcode == OP_JAL || opcode == OP_JALR) ? PCSEL_ALU : PCSEL_PLUS4;
            retire_c    = 1'b1;
            state_d     = S_FETCH;
         end
         S_HALT: begin
            if (resume) begin
               pc_write_c = 1'b1;
               fault_d    = FAULT_NONE;
               state_d    = S_FETCH;
            end
         end
         default: state_d = S_FETCH;
      endcase

      // An ack arriving on the limit cycle has already moved the FSM on.
      wd_expire = WD_ON && wait_req && !wait_ack && (wait_q == WD_LIMIT);
      if (wd_expire) begin
         state_d = S_HALT;
         fault_d = FAULT_TIMEOUT;
      end

      if (state_d != state_q)             wait_d = '0;
      else if (WD_ON && wait_req && !wait_ack) wait_d = wait_q + 1'b1;
      else                                wait_d = wait_q;
   end

   // Reset gates every enable so an aborted instruction leaves no partial write.
   assign imem_req      = imem_req_c  & reset;
   assign dmem_req      = dmem_req_c  & reset;
   assign dmem_we       = dmem_we_c   & reset;
   assign ir_write      = ir_write_c  & reset;
   assign operand_latch = op_latch_c  & reset;
   assign pc_write      = pc_write_c  & reset;
   assign reg_write     = reg_write_c & reset;
   assign pc_sel        = reset ? pc_sel_c : PCSEL_PLUS4;
   assign state         = state_q;
   assign halted        = (state_q == S_HALT);
   assign fault         = fault_q;

   perf_counters u_perf (
      .clk_i         (clk),
      .rst_ni        (reset),
      .inc_i         (retire_c & reset),
      .halt_i        (state_q == S_HALT),
      .cycle_count_o (cycle_count),
      .instret_o     (instret)
   );

endmodule

// File: doc/multicycle_sequencer.md
# multicycle_sequencer

Multicycle control sequencer for the RV32I core: replaces single-cycle execution with a FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK state machine. It steps the shared datapath (PC, instruction register, register file, ALU, data memory) through each instruction. Instruction and data memory are accessed through req/ack handshakes, so wait-state memories are supported. It also raises halt/fault status and maintains cycle and retired-instruction counters. The existing combinational control unit still decodes ALU operation and immediate type; this block owns only when state-changing enables fire.

## Interface
- TIMEOUT, 255, max cycles a req may wait for ack before a bus-timeout fault; 0 disables the watchdog.

- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low (0 = reset asserted).
- opcode  in  7  instruction[6:0] from the instruction register.
- branch_taken  in  1  branch unit comparison result.
- imem_ack  in  1  instruction word valid this cycle.
- dmem_ack  in  1  data access complete this cycle.
- resume  in  1  leave HALT (sampled only in HALT).
- imem_req  out  1  instruction fetch request.
- dmem_req  out  1  data memory request.
- dmem_we  out  1  data request is a store.
- ir_write  out  1  load the instruction register.
- operand_latch  out  1  latch rs1/rs2 data and immediate into the A/B/IMM registers.
- pc_write  out  1  update the PC.
- pc_sel  out  2  00 = PC+4, 01 = ALU result register; 10/11 reserved, never driven.
- reg_write  out  1  register-file write enable.
- state  out  3  current state encoding.
- halted  out  1  high while in HALT.
- fault  out  2  00 none, 01 illegal opcode, 10 bus timeout, 11 ECALL/EBREAK.
- cycle_count  out  32  cycles since reset, excluding HALT.
- instret  out  32  retired instructions.

## Operation
- States: FETCH=0, DECODE=1, EXECUTE=2, MEMORY=3, WRITEBACK=4, HALT=5.
- FETCH: imem_req=1. On imem_ack: ir_write=1, go to DECODE. Without ack: stay.
- DECODE: operand_latch=1.
  - Opcode SYSTEM (1110011): go to HALT, fault=11.
  - Opcode outside {0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111}: go to HALT, fault=01.
  - Otherwise go to EXECUTE.
- EXECUTE:
  - LOAD (0000011) or STORE (0100011): go to MEMORY.
  - BRANCH (1100011): pc_write=1, pc_sel=01 if branch_taken else 00, instruction retires, go to FETCH.
  - All other opcodes: go to WRITEBACK.
- MEMORY: dmem_req=1, dmem_we=1 for STORE.
  - On dmem_ack with STORE: pc_write=1, pc_sel=00, retire, go to FETCH.
  - On dmem_ack with LOAD: go to WRITEBACK.
- WRITEBACK: reg_write=1, pc_write=1, retire, go to FETCH.
  - pc_sel=01 for JAL (1101111) and JALR (1100111); 00 otherwise.
- HALT: all enables and reqs are 0; halted=1; fault holds its value.
  - resume=1: pc_write=1, pc_sel=00, fault cleared to 00, go to FETCH.
- Watchdog: an 8-bit-or-wider wait counter clears on entry to FETCH/MEMORY and increments each cycle a req is unacked.
  - When the counter reaches TIMEOUT with no ack: go to HALT, fault=10, req drops the next cycle.
  - An ack in the same cycle the counter reaches TIMEOUT wins.
- Counters:
  - instret increments on every cycle where retire is set.
  - cycle_count increments every non-HALT cycle.
  - Both wrap modulo 2^32 with no saturation.
- All enables are combinational from state, opcode and acks. State, fault and counters are registered.

## Timing
- Reset values: state=FETCH, fault=00, halted=0, counters=0.
- During reset (reset=0), imem_req is held at 0. imem_req=1 from the first cycle after reset deasserts. All other outputs are 0 out of reset.
- Async reset mid-instruction aborts immediately; any pending req drops in the same delta. No partial writes: pc_write and reg_write are 0 while reset=0.
- With zero-wait memories (ack in the req cycle):
  - R/I/LUI/AUIPC/JAL/JALR: 4 cycles.
  - LOAD: 5 cycles.
  - STORE: 4 cycles.
  - BRANCH: 3 cycles.
- Each memory wait cycle adds 1 cycle to the count.
- Req is asserted for the whole wait and deasserts the cycle after ack. No back-to-back reqs without an intervening state change.
- The retiring enable (pc_write) and the FETCH transition occur on the same edge. The next imem_req is high the following cycle.

## Structure
- Shared package `mc_pkg`: state encoding, opcode class constants, fault codes, pc_sel codes. This package is also used by the datapath top and the bench.
- Sub-module `perf_counters`: cycle_count/instret with inc/halt inputs.
- The FSM, decode and watchdog stay in the top module.

## Test plan
- Reset released, imem_ack tied 1, ADD opcode 0110011 → states 0,1,2,4,0; reg_write and pc_write high in cycle 4; instret=1 after 4 cycles.
- LOAD with dmem_ack delayed 3 cycles → dmem_req high for 4 cycles, dmem_we=0; WRITEBACK reached on cycle 8; cycle_count=8.
- BRANCH with branch_taken=1, then with branch_taken=0 → pc_sel=01, then 00, in EXECUTE; 3 cycles each; reg_write never 1.
- Opcode 1111111 → HALT with fault=01 after DECODE. Then resume=1 → FETCH, fault=00, pc_sel=00.
- TIMEOUT=4, imem_ack held 0 → HALT with fault=10 after 5 cycles; imem_req=0 afterwards; cycle_count frozen.
- reset pulsed low in MEMORY with dmem_req=1 → dmem_req=0 immediately; state=FETCH and counters=0 after release.
